// File: rtl/ysyx_core_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_core_seq_pkg
// Brief   : Shared state encoding and wait-timer width for the NPC sequencer.
// Revision: 1.0
// ============================================================================
package ysyx_core_seq_pkg;

    localparam int c_wait_w = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_WB    = 3'd4,
        ST_HALT  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    // States in which a memory request is outstanding and the timer runs.
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_core_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_core_seq_if
// Brief   : Instruction/data memory request-ack handshake of the sequencer.
// Revision: 1.0
// ============================================================================
interface ysyx_core_seq_if;

    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ack,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ack,
        output dmem_ack
    );

endinterface
`default_nettype wire

// File: rtl/ysyx_core_seq_wait_timer.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_wait_timer
// Brief   : Counts cycles spent waiting for a memory ack; flags TIMEOUT.
// Revision: 1.0
// ============================================================================
module ysyx_wait_timer
    import ysyx_core_seq_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clr,
    input  wire logic i_inc,
    output logic      o_expired
);

    localparam logic [c_wait_w-1:0] c_limit = c_wait_w'(TIMEOUT);
    localparam logic [c_wait_w-1:0] c_one   = c_wait_w'(1);

    logic [c_wait_w-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + c_one;
        end
    end

    // The owner leaves the wait state on expiry, so the count never passes the limit.
    assign o_expired = (r_count == c_limit);

endmodule
`default_nettype wire

// File: rtl/ysyx_core_seq.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_core_seq
// Brief   : Multi-cycle FETCH/EXEC/MEM/WB sequencer with perf counters.
// Revision: 1.0
// ============================================================================
module ysyx_core_seq
    import ysyx_core_seq_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 64
) (
    input  wire logic             clk,
    input  wire logic             rst,
    ysyx_core_seq_if.master       mem,
    input  wire logic             dec_load,
    input  wire logic             dec_store,
    input  wire logic             dec_rf_wr_en,
    input  wire logic             dec_ebreak,
    output logic                  inst_we,
    output logic                  rf_wr_en,
    output logic                  pc_we,
    output logic                  halted,
    output logic                  err,
    output logic [CNT_W-1:0]      cycle_cnt,
    output logic [CNT_W-1:0]      instret_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    state_t           r_state;
    logic             r_imem_req;
    logic             r_dmem_req;
    logic             r_dmem_we;
    logic             r_rf_wr_en;
    logic             r_pc_we;
    logic             r_halted;
    logic             r_err;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instret_cnt;

    logic w_fetch_ack;
    logic w_mem_ack;
    logic w_waiting;
    logic w_ack;
    logic w_expired;

    // Acks are only honoured in their own state; spurious pulses fall away here.
    assign w_fetch_ack = (r_state == ST_FETCH) && mem.imem_ack;
    assign w_mem_ack   = (r_state == ST_MEM)   && mem.dmem_ack;
    assign w_waiting   = is_wait_state(r_state);
    assign w_ack       = w_fetch_ack || w_mem_ack;

    ysyx_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (!w_waiting || w_ack),
        .i_inc     (w_waiting && !w_ack),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_imem_req <= 1'b0;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_rf_wr_en <= 1'b0;
            r_pc_we    <= 1'b0;
            r_halted   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_FETCH;
                    r_imem_req <= 1'b1;
                end
                ST_FETCH: begin
                    // An ack on the expiry cycle still wins over the timeout.
                    if (w_fetch_ack) begin
                        r_state    <= ST_EXEC;
                        r_imem_req <= 1'b0;
                    end else if (w_expired) begin
                        r_state    <= ST_ERR;
                        r_imem_req <= 1'b0;
                        r_err      <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (dec_ebreak) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else if (dec_load || dec_store) begin
                        r_state    <= ST_MEM;
                        r_dmem_req <= 1'b1;
                        r_dmem_we  <= dec_store;
                    end else begin
                        r_state    <= ST_WB;
                        r_pc_we    <= 1'b1;
                        r_rf_wr_en <= dec_rf_wr_en && !dec_store;
                    end
                end
                ST_MEM: begin
                    if (w_mem_ack) begin
                        r_state    <= ST_WB;
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        r_pc_we    <= 1'b1;
                        r_rf_wr_en <= dec_rf_wr_en && !dec_store;
                    end else if (w_expired) begin
                        r_state    <= ST_ERR;
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        r_err      <= 1'b1;
                    end
                end
                ST_WB: begin
                    r_state    <= ST_FETCH;
                    r_pc_we    <= 1'b0;
                    r_rf_wr_en <= 1'b0;
                    r_imem_req <= 1'b1;
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                ST_ERR: begin
                    r_state <= ST_ERR;
                end
                default: begin
                    r_state    <= ST_ERR;
                    r_imem_req <= 1'b0;
                    r_dmem_req <= 1'b0;
                    r_dmem_we  <= 1'b0;
                    r_pc_we    <= 1'b0;
                    r_rf_wr_en <= 1'b0;
                    r_err      <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_cnt <= '0;
        end else if (r_state != ST_HALT && r_state != ST_ERR) begin
            r_cycle_cnt <= r_cycle_cnt + c_cnt_one;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instret_cnt <= '0;
        end else if (r_state == ST_WB) begin
            r_instret_cnt <= r_instret_cnt + c_cnt_one;
        end
    end

    assign mem.imem_req = r_imem_req;
    assign mem.dmem_req = r_dmem_req;
    assign mem.dmem_we  = r_dmem_we;
    assign inst_we      = w_fetch_ack;
    assign rf_wr_en     = r_rf_wr_en;
    assign pc_we        = r_pc_we;
    assign halted       = r_halted;
    assign err          = r_err;
    assign cycle_cnt    = r_cycle_cnt;
    assign instret_cnt  = r_instret_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_core_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_ysyx_core_seq
// Brief   : Randomized scoreboard bench for the NPC multi-cycle sequencer.
// Revision: 1.0
// ============================================================================
module tb_ysyx_core_seq;

    localparam int c_timeout = 4;
    localparam int c_n_inst  = 40;

    typedef struct {
        bit ld;
        bit st;
        bit rf;
        int fw;
        int dw;
    } ins_t;

    typedef struct {
        longint wb_cycle;
        int     idx;
        bit     rf_exp;
        bit     is_store;
        int     imem_cycles;
        int     dmem_cycles;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_load, dec_store, dec_rf_wr_en, dec_ebreak;
    logic        inst_we, rf_wr_en, pc_we, halted, err;
    logic [63:0] cycle_cnt, instret_cnt;

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    rec_t sb[$];

    int imem_cyc = 0;
    int dmem_cyc = 0;
    int instwe_n = 0;

    always #5 clk = ~clk;

    ysyx_core_seq_if bus ();

    ysyx_core_seq #(
        .TIMEOUT (c_timeout),
        .CNT_W   (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem          (bus),
        .dec_load     (dec_load),
        .dec_store    (dec_store),
        .dec_rf_wr_en (dec_rf_wr_en),
        .dec_ebreak   (dec_ebreak),
        .inst_we      (inst_we),
        .rf_wr_en     (rf_wr_en),
        .pc_we        (pc_we),
        .halted       (halted),
        .err          (err),
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Three directed instructions first, then random mixes with waits 0..TIMEOUT.
    function automatic ins_t gen(input int idx);
        ins_t t;
        int   k;
        k    = int'($urandom_range(0, 9));
        t.ld = (k == 5 || k == 6 || k == 9);
        t.st = (k == 7 || k == 8 || k == 9);
        t.rf = 1'($urandom_range(0, 1));
        t.fw = int'($urandom_range(0, c_timeout));
        t.dw = int'($urandom_range(0, c_timeout));
        if (idx == 0) begin t.ld = 0; t.st = 0; t.rf = 1; t.fw = 0; t.dw = 0; end
        if (idx == 1) begin t.ld = 1; t.st = 0; t.rf = 1; t.fw = 1; t.dw = 3; end
        if (idx == 2) begin t.ld = 0; t.st = 1; t.rf = 1; t.fw = 0; t.dw = 0; end
        return t;
    endfunction

    // Monitor: per-cycle invariants, and a retire check whenever pc_we shows up.
    always @(negedge clk) begin
        #1;
        if (mon_en && !rst) begin
            if (bus.imem_req) imem_cyc++;
            if (inst_we) instwe_n++;
            if (bus.dmem_req) begin
                dmem_cyc++;
                if (sb.size() == 0) chk("dmem_req_unexpected", 1, 0);
                else chk("dmem_we", bus.dmem_we, sb[0].is_store);
            end
            if (rf_wr_en && !pc_we) chk("rf_wr_en_outside_wb", 1, 0);
            if (pc_we) begin
                if (sb.size() == 0) begin
                    chk("pc_we_unexpected", 1, 0);
                end else begin
                    rec_t r;
                    r = sb.pop_front();
                    chk("wb_cycle", cycle_cnt, r.wb_cycle);
                    chk("instret_in_wb", instret_cnt, r.idx);
                    chk("rf_wr_en", rf_wr_en, r.rf_exp);
                    chk("imem_req_cycles", imem_cyc, r.imem_cycles);
                    chk("dmem_req_cycles", dmem_cyc, r.dmem_cycles);
                    chk("inst_we_pulses", instwe_n, 1);
                end
                imem_cyc = 0;
                dmem_cyc = 0;
                instwe_n = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual=%0d required=%0d", 1, 0);
        $fatal(1, "watchdog expired");
    end

    initial begin
        ins_t   nxt, cur;
        rec_t   r;
        int     fcnt, dcnt, n_issued;
        longint t_start, t_halt;
        bit     seen;

        rst = 1'b1;
        bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
        dec_load = 0; dec_store = 0; dec_rf_wr_en = 0; dec_ebreak = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_imem_req", bus.imem_req, 0);
        chk("rst_dmem_req", bus.dmem_req, 0);
        chk("rst_pc_we", pc_we, 0);
        chk("rst_halted", halted, 0);
        chk("rst_err", err, 0);
        chk("rst_cycle_cnt", cycle_cnt, 0);
        chk("rst_instret", instret_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // Random run: the responder reacts to requests with the planned waits.
        cur = gen(0);
        nxt = cur;
        t_start = 1; fcnt = 0; dcnt = 0; n_issued = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (n_issued == c_n_inst && sb.size() == 0) break;
            @(negedge clk);
            bus.imem_ack = 1'b0;
            bus.dmem_ack = 1'b0;
            if (bus.imem_req && n_issued < c_n_inst) begin
                if (fcnt == nxt.fw) begin
                    bus.imem_ack = 1'b1;
                    fcnt = 0;
                    cur = nxt;
                    dec_load = cur.ld; dec_store = cur.st;
                    dec_rf_wr_en = cur.rf; dec_ebreak = 1'b0;
                    r.idx         = n_issued;
                    r.is_store    = cur.st;
                    r.rf_exp      = cur.rf && !cur.st;
                    r.imem_cycles = cur.fw + 1;
                    r.dmem_cycles = (cur.ld || cur.st) ? cur.dw + 1 : 0;
                    r.wb_cycle    = t_start + cur.fw + 1 + ((cur.ld || cur.st) ? cur.dw + 2 : 1);
                    t_start       = r.wb_cycle + 1;
                    sb.push_back(r);
                    n_issued++;
                    nxt = gen(n_issued);
                end else begin
                    fcnt++;
                end
            end
            if (bus.dmem_req) begin
                if (dcnt == cur.dw) begin
                    bus.dmem_ack = 1'b1;
                    dcnt = 0;
                end else begin
                    dcnt++;
                end
            end
        end
        chk("run_all_retired", (n_issued == c_n_inst && sb.size() == 0), 1);

        // ebreak fetched with zero wait; loads/writes must not take priority.
        bus.imem_ack = 1'b1;
        dec_ebreak = 1'b1; dec_load = 1'b1; dec_store = 1'b0; dec_rf_wr_en = 1'b1;
        t_halt = t_start + 2;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        @(negedge clk);
        #1;
        chk("halt_halted", halted, 1);
        chk("halt_instret", instret_cnt, c_n_inst);
        chk("halt_cycle_cnt", cycle_cnt, t_halt);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.imem_ack = 1'b1;
            bus.dmem_ack = 1'b1;
            #1;
            chk("halt_spurious_imem_req", bus.imem_req, 0);
            chk("halt_spurious_dmem_req", bus.dmem_req, 0);
            chk("halt_inst_we", inst_we, 0);
            chk("halt_frozen_cycle_cnt", cycle_cnt, t_halt);
        end
        @(negedge clk);
        bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
        #1;
        chk("halt_still_halted", halted, 1);
        chk("halt_instret_stays", instret_cnt, c_n_inst);

        // Restart, reach MEM on a load, then reset while the request is open.
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst2_halted", halted, 0);
        chk("rst2_cycle_cnt", cycle_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        dec_ebreak = 0; dec_load = 1; dec_store = 0; dec_rf_wr_en = 1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.imem_req;
        end
        chk("rst3_fetch_seen", seen, 1);
        bus.imem_ack = 1'b1;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.dmem_req;
        end
        chk("rst3_mem_seen", seen, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midmem_dmem_req", bus.dmem_req, 0);
        chk("midmem_imem_req", bus.imem_req, 0);
        chk("midmem_pc_we", pc_we, 0);
        chk("midmem_rf_wr_en", rf_wr_en, 0);
        chk("midmem_cycle_cnt", cycle_cnt, 0);
        chk("midmem_instret", instret_cnt, 0);
        bus.dmem_ack = 1'b1;
        @(negedge clk);
        bus.dmem_ack = 1'b0;
        dec_load = 0; dec_rf_wr_en = 0;
        rst = 1'b0;
        #1;
        chk("restart_idle_imem_req", bus.imem_req, 0);
        chk("restart_idle_pc_we", pc_we, 0);

        // No imem ack from here on: FETCH lasts TIMEOUT+1 cycles, then ERR.
        @(negedge clk);
        #1;
        chk("restart_fetch_imem_req", bus.imem_req, 1);
        chk("restart_cycle_cnt", cycle_cnt, 1);
        for (int k = 2; k <= c_timeout + 1; k++) begin
            @(negedge clk);
            #1;
            chk("timeout_waiting_imem_req", bus.imem_req, 1);
            chk("timeout_waiting_err", err, 0);
        end
        @(negedge clk);
        #1;
        chk("timeout_err", err, 1);
        chk("timeout_imem_req_drop", bus.imem_req, 0);
        chk("timeout_cycle_cnt", cycle_cnt, c_timeout + 2);
        repeat (3) @(negedge clk);
        #1;
        chk("timeout_cycle_cnt_frozen", cycle_cnt, c_timeout + 2);
        chk("timeout_err_held", err, 1);
        chk("timeout_not_halted", halted, 0);
        chk("timeout_instret", instret_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_core_seq.md
Name: ysyx_core_seq

Overview:
Multi-cycle sequencer for the NPC execute datapath (ALU, register file, jump-address path). It steps each instruction through fetch, execute, memory and write-back. It handshakes with the instruction and data memory ports and gates the register-file and PC write enables so that architectural state changes only once per instruction. It also keeps cycle and retired-instruction counters and stops the core on ebreak or on a memory timeout.

Parameters:
TIMEOUT, 255, maximum cycles to wait for a memory ack before entering ERR (1..65535)
CNT_W, 64, width of the cycle and instret counters

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
imem_req  out  1  instruction fetch request, held until ack
imem_ack  in  1  one-cycle pulse: instruction data valid this cycle
dmem_req  out  1  data memory request, held until ack
dmem_we  out  1  data request is a store (valid only with dmem_req)
dmem_ack  in  1  one-cycle pulse: load data valid / store accepted
dec_load  in  1  decoded instruction is a load
dec_store  in  1  decoded instruction is a store
dec_rf_wr_en  in  1  decoded instruction writes rd
dec_ebreak  in  1  decoded instruction is ebreak
inst_we  out  1  latch fetched instruction into IR
rf_wr_en  out  1  register-file write enable (gated decoder enable)
pc_we  out  1  PC update enable (PC takes jump_addr or pc+4 per datapath)
halted  out  1  core stopped by ebreak
err  out  1  core stopped by memory timeout
cycle_cnt  out  CNT_W  cycles since reset
instret_cnt  out  CNT_W  retired instructions since reset

Behaviour:
- Reset is asynchronous and active-high. Asserting rst forces these values immediately:
  - state = IDLE
  - wait counter = 0
  - both performance counters = 0
  - all 1-bit outputs = 0
- Reset mid-operation (any state, including an outstanding request) aborts the request with no write. An ack arriving while rst is high is ignored.
- States are IDLE, FETCH, EXEC, MEM, WB, HALT, ERR. All outputs are Moore functions of state, except inst_we, which is Mealy.
- IDLE: outputs 0; go to FETCH on the next clock.
- FETCH: imem_req = 1.
  - If imem_ack = 1 in the same cycle: inst_we = 1 (combinational), go to EXEC.
  - Zero-wait memory therefore gives FETCH a 1-cycle minimum.
- EXEC: one cycle; decoder and ALU settle from the IR.
  - dec_ebreak = 1 → HALT (no pc_we, not counted as retired).
  - Else dec_load or dec_store = 1 → MEM.
  - Else → WB.
- MEM: dmem_req = 1, dmem_we = dec_store.
  - On dmem_ack → WB.
  - If dec_load and dec_store are both 1 (illegal), treat it as a store.
- WB: one cycle.
  - pc_we = 1.
  - rf_wr_en = dec_rf_wr_en AND NOT dec_store.
  - instret_cnt increments by 1.
  - Go to FETCH.
- HALT: halted = 1; terminal until reset; all requests 0.
- ERR: err = 1; terminal until reset; all requests 0.
- Wait counter (16 bits): cleared on entry to FETCH and MEM; increments each cycle in FETCH/MEM without ack.
  - If it reaches TIMEOUT with no ack, go to ERR on that clock.
  - An ack in the same cycle the count reaches TIMEOUT wins: proceed normally.
- Spurious acks (imem_ack outside FETCH, dmem_ack outside MEM) are ignored; no state change.
- Requests must not drop while waiting; the memory side may ack in any cycle, including the first cycle of the request.
- cycle_cnt increments every clock outside reset, HALT and ERR, and freezes in HALT/ERR.
- Both counters wrap modulo 2^CNT_W.
- Instruction latency with zero-wait memory:
  - ALU/jump instruction: 3 cycles (FETCH, EXEC, WB).
  - Load/store: 4 cycles (adds MEM).
- Exactly one pc_we pulse per retired instruction; rf_wr_en is never high outside WB.

Decomposition:
- Shared package: state encoding enum (3 bits: IDLE=0, FETCH=1, EXEC=2, MEM=3, WB=4, HALT=5, ERR=6) and the wait-counter width constant (16).
- One sub-module is natural: ysyx_wait_timer, holding the clear/increment/expire logic. The FSM instantiates it once and drives its clear on FETCH/MEM entry.

Test Plan:
- Reset, then zero-wait imem and an ALU instruction with dec_rf_wr_en = 1 → imem_req high on cycle 1, inst_we on cycle 1, WB on cycle 3 with rf_wr_en = 1 and pc_we = 1, instret_cnt = 1.
- Load with imem latency 2 and dmem_ack after 3 cycles → dmem_req held 4 cycles with dmem_we = 0, then a single rf_wr_en pulse; the instruction takes 8 cycles total.
- Store with dec_rf_wr_en forced to 1 → dmem_we = 1 during MEM, rf_wr_en stays 0 in WB, pc_we = 1.
- TIMEOUT = 4 and imem_ack never arrives → err = 1 after 5 FETCH cycles, imem_req drops, cycle_cnt freezes.
- dec_ebreak in EXEC after 2 retired instructions → halted = 1, instret_cnt stays 2, no further requests; spurious imem_ack is ignored.
- rst pulsed mid-MEM while dmem_req is high → outputs 0 immediately, counters 0, restart at IDLE → FETCH; the late dmem_ack is ignored.
